// File: rtl/ber_checker.sv
// ber_checker: multi-channel bit-error-rate meter.
// Each channel searches the loop latency between the slicer decision and the
// local PRBS reference, locks once a window is clean enough, then accumulates
// saturating bit and error counts.
// Optional feature macro: BER_CHECKER_RESYNC_EN (lock-loss detection and
// re-search, adds o_resync_cnt).
module ber_checker #(
  parameter int NCH       = 2,
  parameter int MAX_DELAY = 512,
  parameter int NB_DELAY  = 9,
  parameter int SYNC_LEN  = 511,
  parameter int SYNC_THR  = 8,
  parameter int NB_CNT    = 64
) (
  input  logic                   clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_clear,
  input  logic [NCH-1:0]         i_rx_bit,
  input  logic [NCH-1:0]         i_ref_bit,
  output logic [NCH-1:0]         o_locked,
  output logic [NCH*NB_DELAY-1:0] o_delay,
  output logic [NCH*NB_CNT-1:0]  o_bit_cnt,
  output logic [NCH*NB_CNT-1:0]  o_err_cnt
`ifdef BER_CHECKER_RESYNC_EN
  ,
  output logic [NCH*16-1:0]      o_resync_cnt
`endif
);

  localparam int NB_WIN = $clog2(SYNC_LEN + 1);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [MAX_DELAY-2:0] hist;
    logic [MAX_DELAY-1:0] taps;
    logic [0:0]           state;
    logic [NB_DELAY-1:0]  d;
    logic [NB_DELAY-1:0]  d_inc;
    logic [NB_WIN-1:0]    wcnt;
    logic [NB_WIN-1:0]    werr;
    logic [NB_WIN-1:0]    werr_nxt;
    logic [NB_CNT-1:0]    bit_cnt;
    logic [NB_CNT-1:0]    err_cnt;
    logic                 err;
    logic                 win_end;
    logic                 win_ok;
    logic                 lock_evt;

    // Tap 0 is the reference bit arriving now; tap d is the bit from d strobes ago.
    assign taps     = {hist, i_ref_bit[k]};
    assign err      = i_rx_bit[k] ^ taps[d];
    assign win_end  = i_valid && (wcnt == NB_WIN'(SYNC_LEN - 1));
    assign werr_nxt = werr + NB_WIN'(err);
    assign win_ok   = (32'(werr_nxt) <= 32'(SYNC_THR));
    assign d_inc    = (d == NB_DELAY'(MAX_DELAY - 1)) ? '0 : d + NB_DELAY'(1);
    assign lock_evt = win_end && (state == SEARCH) && win_ok;

    // Reference delay line, advanced once per baud strobe.
    always_ff @(posedge clk) begin
      if (i_reset)
        hist <= '0;
      else if (i_valid)
        hist <= {hist[MAX_DELAY-3:0], i_ref_bit[k]};
    end

`ifdef BER_CHECKER_RESYNC_EN
    logic        loss_evt;
    logic [15:0] rcnt;

    assign loss_evt = win_end && (state == LOCKED) &&
                      (32'(werr_nxt) > 32'(4 * SYNC_THR));

    // Saturating count of lock losses.
    always_ff @(posedge clk) begin
      if (i_reset)
        rcnt <= '0;
      else if (loss_evt && (rcnt != '1))
        rcnt <= rcnt + 16'd1;
    end

    assign o_resync_cnt[k*16 +: 16] = rcnt;
`endif

    // Alignment FSM and window counters; windows keep running while locked so
    // that optional lock-loss monitoring shares the same window phase.
    always_ff @(posedge clk) begin
      if (i_reset) begin
        state <= SEARCH;
        d     <= '0;
        wcnt  <= '0;
        werr  <= '0;
      end else if (i_valid) begin
        if (win_end) begin
          wcnt <= '0;
          werr <= '0;
          if (state == SEARCH) begin
            if (win_ok)
              state <= LOCKED;
            else
              d <= d_inc;
          end
`ifdef BER_CHECKER_RESYNC_EN
          else if (loss_evt) begin
            state <= SEARCH;
            d     <= d_inc;
          end
`endif
        end else begin
          wcnt <= wcnt + NB_WIN'(1);
          werr <= werr_nxt;
        end
      end
    end

    // Bit/error accumulation while locked; both freeze once bit_cnt saturates.
    always_ff @(posedge clk) begin
      if (i_reset || i_clear || (i_valid && lock_evt)) begin
        bit_cnt <= '0;
        err_cnt <= '0;
      end else if (i_valid && (state == LOCKED) && (bit_cnt != '1)) begin
        bit_cnt <= bit_cnt + NB_CNT'(1);
        err_cnt <= err_cnt + NB_CNT'(err);
      end
    end

    assign o_locked[k]                     = (state == LOCKED);
    assign o_delay[k*NB_DELAY +: NB_DELAY] = d;
    assign o_bit_cnt[k*NB_CNT +: NB_CNT]   = bit_cnt;
    assign o_err_cnt[k*NB_CNT +: NB_CNT]   = err_cnt;
  end

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: scoreboard bench for ber_checker.
// Uses a short delay line (16 taps) so a full delay sweep and wrap fits in a
// short run, and 14-bit counters so saturation is reachable.
module tb_ber_checker;

  localparam int NCH       = 2;
  localparam int MAX_DELAY = 16;
  localparam int NB_DELAY  = 4;
  localparam int SYNC_LEN  = 511;
  localparam int SYNC_THR  = 8;
  localparam int NB_CNT    = 14;

  localparam int SEL_LOCK = 0;
  localparam int SEL_DLY  = 1;
  localparam int SEL_BIT  = 2;
  localparam int SEL_ERR  = 3;
  localparam int SEL_RSY  = 4;

  logic                    clk = 1'b0;
  logic                    i_reset = 1'b1;
  logic                    i_valid = 1'b0;
  logic                    i_clear = 1'b0;
  logic [NCH-1:0]          i_rx_bit = '0;
  logic [NCH-1:0]          i_ref_bit = '0;
  logic [NCH-1:0]          o_locked;
  logic [NCH*NB_DELAY-1:0] o_delay;
  logic [NCH*NB_CNT-1:0]   o_bit_cnt;
  logic [NCH*NB_CNT-1:0]   o_err_cnt;
`ifdef BER_CHECKER_RESYNC_EN
  logic [NCH*16-1:0]       o_resync_cnt;
`endif

  always #5 clk = ~clk;

  ber_checker #(
    .NCH(NCH), .MAX_DELAY(MAX_DELAY), .NB_DELAY(NB_DELAY),
    .SYNC_LEN(SYNC_LEN), .SYNC_THR(SYNC_THR), .NB_CNT(NB_CNT)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_valid(i_valid), .i_clear(i_clear),
    .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .o_locked(o_locked),
    .o_delay(o_delay), .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt)
`ifdef BER_CHECKER_RESYNC_EN
    , .o_resync_cnt(o_resync_cnt)
`endif
  );

  typedef struct {
    string       tag;
    int          sel;
    int          ch;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Stimulus state: PRBS9 generator, reference history, per-channel rx delay.
  logic [8:0]  lfsr = 9'h1FF;
  logic [15:0] h    = '0;
  int          dly[NCH];
  logic [1:0]  inv  = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel, input int ch);
    case (sel)
      SEL_LOCK: return 64'(o_locked[ch]);
      SEL_DLY:  return 64'(o_delay[ch*NB_DELAY +: NB_DELAY]);
      SEL_BIT:  return 64'(o_bit_cnt[ch*NB_CNT +: NB_CNT]);
      SEL_ERR:  return 64'(o_err_cnt[ch*NB_CNT +: NB_CNT]);
`ifdef BER_CHECKER_RESYNC_EN
      SEL_RSY:  return 64'(o_resync_cnt[ch*16 +: 16]);
`endif
      default:  return 64'hDEAD;
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input int ch, input logic [63:0] v);
    exp_t e;
    e.tag = tag; e.sel = sel; e.ch = ch; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic expect_chan(input string tag, input int ch, input int lk, input int dl,
                             input int bits, input int errs);
    expect_out({tag, "_lock"}, SEL_LOCK, ch, 64'(lk));
    expect_out({tag, "_dly"},  SEL_DLY,  ch, 64'(dl));
    expect_out({tag, "_bits"}, SEL_BIT,  ch, 64'(bits));
    expect_out({tag, "_errs"}, SEL_ERR,  ch, 64'(errs));
  endtask

  // One clock: inputs were set before the edge, outputs checked 1 ns after it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, observe(e.sel, e.ch), e.exp);
    end
  endtask

  task automatic strobe(input logic [1:0] flip, input logic clr);
    logic b;
    b    = lfsr[8];
    lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    h    = {h[14:0], b};
    i_ref_bit = {b, b};
    for (int ch = 0; ch < NCH; ch++)
      i_rx_bit[ch] = h[dly[ch]] ^ inv[ch] ^ flip[ch];
    i_valid = 1'b1;
    i_clear = clr;
  endtask

  task automatic idle(input logic clr);
    i_valid   = 1'b0;
    i_clear   = clr;
    i_rx_bit  = NCH'($urandom);
    i_ref_bit = NCH'($urandom);
  endtask

  int  e_cnt;
  int  ok;
  bit  seen;

  initial begin
    dly[0] = 5;
    dly[1] = 5;

    // Reset state
    i_reset = 1'b1;
    idle(1'b0);
    step();
    for (int ch = 0; ch < NCH; ch++) expect_chan("rst", ch, 0, 0, 0, 0);
    step();
    i_reset = 1'b0;
    h = '0;

    // First lock at delay 5, exactly 6 windows of strobes
    for (int i = 1; i <= 6 * SYNC_LEN; i++) begin
      strobe(2'b00, 1'b0);
      if (i == SYNC_LEN) expect_out("win1_dly", SEL_DLY, 0, 64'd1);
      if (i == 6 * SYNC_LEN - 1) begin
        expect_out("prelock0", SEL_LOCK, 0, 64'd0);
        expect_out("prelock1", SEL_LOCK, 1, 64'd0);
      end
      if (i == 6 * SYNC_LEN)
        for (int ch = 0; ch < NCH; ch++) expect_chan("lock", ch, 1, 5, 0, 0);
      step();
    end

    // 10000 strobes, sparse valid, I flipped every 100th bit
    for (int i = 0; i < 10000; i++) begin
      if ((i % 7) == 3) begin
        idle(1'b0);
        step();
      end
      strobe({1'b0, (i % 100) == 99}, 1'b0);
      if (i == 9999) begin
        expect_chan("ber_i", 0, 1, 5, 10000, 100);
        expect_chan("ber_q", 1, 1, 5, 10000, 0);
      end
      step();
    end

    // Run to counter saturation, then confirm errors are no longer counted
    for (int i = 0; i < 16383 - 10000; i++) begin
      strobe(2'b00, 1'b0);
      if (i == 16383 - 10000 - 1) expect_out("sat_bits", SEL_BIT, 0, 64'd16383);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      strobe(2'b01, 1'b0);
      if (i == 4) expect_chan("sat_frz", 0, 1, 5, 16383, 100);
      step();
    end

    // Clear on an errored strobe
    strobe(2'b01, 1'b1);
    for (int ch = 0; ch < NCH; ch++) expect_chan("clr", ch, 1, 5, 0, 0);
    step();
    strobe(2'b00, 1'b0);
    expect_out("clr_next_i", SEL_BIT, 0, 64'd1);
    expect_out("clr_next_q", SEL_BIT, 1, 64'd1);
    step();

    // Loop delay changes 5 -> 7 after lock
    idle(1'b1);
    step();
    dly[0] = 7;
    dly[1] = 7;
`ifdef BER_CHECKER_RESYNC_EN
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      strobe(2'b00, 1'b0);
      step();
      if (o_locked == 2'b00) seen = 1'b1;
    end
    check_val("resync_drop", 64'(seen), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 1200 && !seen; i++) begin
      strobe(2'b00, 1'b0);
      step();
      if (o_locked == 2'b11) seen = 1'b1;
    end
    check_val("resync_relock", 64'(seen), 64'd1);
    idle(1'b0);
    for (int ch = 0; ch < NCH; ch++) begin
      expect_out("resync_dly", SEL_DLY, ch, 64'd7);
      expect_out("resync_cnt", SEL_RSY, ch, 64'd1);
    end
    step();
`else
    e_cnt = 0;
    for (int i = 0; i < 2 * SYNC_LEN; i++) begin
      strobe(2'b00, 1'b0);
      if (h[7] != h[5]) e_cnt++;
      if (i == 2 * SYNC_LEN - 1)
        for (int ch = 0; ch < NCH; ch++) expect_chan("dchg", ch, 1, 5, 2 * SYNC_LEN, e_cnt);
      step();
    end
    ok = (e_cnt > SYNC_LEN / 2 && e_cnt < 3 * SYNC_LEN / 2) ? 1 : 0;
    check_val("dchg_half", 64'(ok), 64'd1);
`endif

    // Reset while locked; relock I at delay 5, Q inverted sweeps and wraps
    i_reset = 1'b1;
    idle(1'b0);
    for (int ch = 0; ch < NCH; ch++) begin
      expect_chan("rst2", ch, 0, 0, 0, 0);
`ifdef BER_CHECKER_RESYNC_EN
      expect_out("rst2_rsy", SEL_RSY, ch, 64'd0);
`endif
    end
    step();
    i_reset = 1'b0;
    h = '0;
    dly[0] = 5;
    dly[1] = 5;
    inv = 2'b10;
    for (int i = 1; i <= MAX_DELAY * SYNC_LEN; i++) begin
      strobe(2'b00, 1'b0);
      if (i == 6 * SYNC_LEN - 1) expect_out("relock_pre", SEL_LOCK, 0, 64'd0);
      if (i == 6 * SYNC_LEN) begin
        expect_chan("relock_i", 0, 1, 5, 0, 0);
        expect_out("q_dly6", SEL_DLY, 1, 64'd6);
      end
      if (i == (MAX_DELAY - 1) * SYNC_LEN) expect_out("q_dly15", SEL_DLY, 1, 64'd15);
      if (i == MAX_DELAY * SYNC_LEN) begin
        expect_chan("wrap_q", 1, 0, 0, 0, 0);
        expect_chan("wrap_i", 0, 1, 5, MAX_DELAY * SYNC_LEN - 6 * SYNC_LEN, 0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
